actuator_interlock: RTL
=======================

Name: actuator_interlock

Overview:
- Sits directly downstream of the washing-machine register machine.
- Consumes its four raw control strobes (fill, release, forward, reverse) and drives the physical valve and motor outputs.
- Enforces safety rules:
  - motor direction mutual exclusion
  - mandatory motor dead time between any two run intervals
  - drain priority over fill
  - door interlock
  - a sticky fault that forces a safe state

Parameters:
- DEAD_CYCLES, 4: clock cycles the motor must be fully off between any two run intervals; legal range >= 1.
- CNT_WIDTH, $clog2(DEAD_CYCLES+1): width of the dead-time counter; derived, not overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- ctrl_fill  input  1  fill request from processor
- ctrl_release  input  1  drain request from processor
- ctrl_forward  input  1  motor forward request
- ctrl_reverse  input  1  motor reverse request
- door_closed  input  1  door sensor, 1 = closed and latched
- valve_in  output  1  inlet valve drive
- valve_out  output  1  drain valve drive
- motor_fwd  output  1  motor forward drive
- motor_rev  output  1  motor reverse drive
- dead_busy  output  1  1 while dead-time interval is running
- fault  output  1  sticky protocol fault

Behaviour:
- One clock domain. Reset is synchronous and active-low: sampled on the rising edge of clk while rst_n=0; no asynchronous term.
- All outputs are registered. Reset values are 0 for every output, motor FSM = M_IDLE, counter = 0, fault = 0.
- Latency: a request sampled at edge N appears on outputs after edge N; no combinational input-to-output path.
- Effective requests:
  - fwd_q = ctrl_forward & door_closed & ~fault
  - rev_q = ctrl_reverse & door_closed & ~fault
- Fault set: ctrl_forward & ctrl_reverse both 1 on the same sampled edge, in any state and regardless of door_closed.
  - fault goes 1 after that edge.
  - It stays 1 until rst_n; no other clear.
- Valves (registered):
  - valve_out = ctrl_release | fault
  - valve_in = ctrl_fill & ~ctrl_release & door_closed & ~fault
  - If fill and release are requested together, release wins. This is not a fault.
- Motor FSM states: M_IDLE, M_FWD, M_REV, M_DEAD.
  - M_IDLE: motor_fwd = motor_rev = 0.
    - fwd_q & ~rev_q -> M_FWD
    - rev_q & ~fwd_q -> M_REV
    - otherwise stay.
  - M_FWD: motor_fwd = 1.
    - Stay while fwd_q & ~rev_q.
    - Any other condition (drop, reverse, both, door open, fault) -> M_DEAD, load counter = DEAD_CYCLES-1.
  - M_REV: mirror of M_FWD.
  - M_DEAD: both motor outputs 0, dead_busy = 1.
    - Counter != 0: decrement and stay.
    - Counter == 0: apply the M_IDLE decision directly, so the motor is off for exactly DEAD_CYCLES cycles.
- Dead time applies to every stop, including a restart in the same direction.
- motor_fwd and motor_rev must never both be 1. Between a 1->0 fall and the next 0->1 rise of either motor output there are at least DEAD_CYCLES cycles with both at 0.
- Counter never wraps: it only decrements from a nonzero value.
- Reset during M_DEAD or a run: next state is M_IDLE with counter 0; no residual dead time is owed.

Decomposition:
- Shared package wash_pkg holds:
  - motor state enum (M_IDLE, M_FWD, M_REV, M_DEAD)
  - DEAD_CYCLES default constant
- One sub-module, dead_timer: loadable down-counter with load/value/zero flag, reusable by later spin-timing blocks.
- Valve and fault logic stay in the top of actuator_interlock.

Test Plan (DEAD_CYCLES=4):
1. rst_n=0 for 2 cycles with all ctrl inputs 1 and door_closed=1 -> all six outputs 0, fault 0 throughout reset; from the first cycle after rst_n=1, fault stays 0 as long as fwd and rev are never both 1.
2. door_closed=1, ctrl_forward=1 sampled at edge 0 -> motor_fwd=1 after edge 0.
   - Switch to ctrl_reverse only at edge 10 -> motor_fwd=0 after edge 10.
   - dead_busy=1 for cycles after edges 10-13.
   - motor_rev=1 after edge 14.
3. ctrl_forward=ctrl_reverse=1 at one edge -> fault=1, motor outputs 0 within 1 cycle, valve_out=1, valve_in=0. All stay so with inputs at 0 until rst_n pulse, then return to 0.
4. ctrl_fill=1 with ctrl_release=0 -> valve_in=1, valve_out=0 after 1 edge; then ctrl_release=1 -> valve_in=0, valve_out=1 after the next edge.
5. During M_FWD drop door_closed -> motor_fwd=0 next cycle, 4 dead cycles.
   - Restore door with ctrl_forward held -> motor_fwd=1 only after the dead interval ends.
   - valve_in blocked while door open.
6. Assert rst_n=0 for one edge in the middle of M_DEAD (counter=2) with ctrl_forward=1 -> outputs 0 after that edge.
   - After rst_n=1, state is M_IDLE, so motor_fwd=1 one edge later with no dead interval.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine actuator blocks.
// Holds the motor state encoding and the default motor dead time.
package wash_pkg;

  localparam int DEAD_CYCLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_FWD  = 2'd1,
    M_REV  = 2'd2,
    M_DEAD = 2'd3
  } motor_state_t;

  // Run decision from a stopped motor; shared by idle and end-of-dead-time.
  function automatic motor_state_t idle_decision(input logic fwd_q, input logic rev_q);
    if (fwd_q && !rev_q) return M_FWD;
    if (rev_q && !fwd_q) return M_REV;
    return M_IDLE;
  endfunction

endpackage

// File: rtl/actuator_interlock_dead_timer.sv
// Loadable down-counter with a zero flag. It saturates at zero and never wraps.
// Load takes priority over decrement.
module dead_timer
  import wash_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values, whatever order the always blocks run in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/actuator_interlock.sv
// Safety interlock between the control processor strobes and the valve/motor drives:
// direction exclusion, motor dead time, drain-over-fill, door interlock, sticky fault.
module actuator_interlock
  import wash_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  localparam int CNT_WIDTH  = $clog2(DEAD_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ctrl_fill,
  input  logic ctrl_release,
  input  logic ctrl_forward,
  input  logic ctrl_reverse,
  input  logic door_closed,
  output logic valve_in,
  output logic valve_out,
  output logic motor_fwd,
  output logic motor_rev,
  output logic dead_busy,
  output logic fault
);

  localparam logic [CNT_WIDTH-1:0] DEAD_LOAD = CNT_WIDTH'(DEAD_CYCLES - 1);

  motor_state_t         state;
  motor_state_t         state_next;
  logic                 fault_next;
  logic                 fwd_q;
  logic                 rev_q;
  logic                 cnt_load;
  logic                 cnt_en;
  logic                 cnt_zero;
  logic [CNT_WIDTH-1:0] dead_cnt;

  // Conflicting directions latch the fault on the same edge, door or no door.
  assign fault_next = fault | (ctrl_forward & ctrl_reverse);
  assign fwd_q      = ctrl_forward & door_closed & ~fault;
  assign rev_q      = ctrl_reverse & door_closed & ~fault;

  dead_timer #(
    .WIDTH(CNT_WIDTH)
  ) u_dead_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_value(DEAD_LOAD),
    .en        (cnt_en),
    .value     (dead_cnt),
    .zero      (cnt_zero)
  );

  // NOTE: every variable written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      M_IDLE: state_next = idle_decision(fwd_q, rev_q);
      M_FWD: begin
        if (!(fwd_q && !rev_q)) begin
          state_next = M_DEAD;
          cnt_load   = 1'b1;
        end
      end
      M_REV: begin
        if (!(rev_q && !fwd_q)) begin
          state_next = M_DEAD;
          cnt_load   = 1'b1;
        end
      end
      M_DEAD: begin
        // Deciding on the zero cycle itself keeps the off time at exactly DEAD_CYCLES.
        if (!cnt_zero) cnt_en = 1'b1;
        else           state_next = idle_decision(fwd_q, rev_q);
      end
      default: state_next = M_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and registered, so no input reaches a pin combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= M_IDLE;
      fault     <= 1'b0;
      valve_in  <= 1'b0;
      valve_out <= 1'b0;
      motor_fwd <= 1'b0;
      motor_rev <= 1'b0;
      dead_busy <= 1'b0;
    end else begin
      state     <= state_next;
      fault     <= fault_next;
      valve_out <= ctrl_release | fault_next;
      valve_in  <= ctrl_fill & ~ctrl_release & door_closed & ~fault_next;
      motor_fwd <= (state_next == M_FWD);
      motor_rev <= (state_next == M_REV);
      dead_busy <= (state_next == M_DEAD);
    end
  end

  a_dir_exclusive : assert property (@(posedge clk) !(motor_fwd && motor_rev));
  a_cnt_range     : assert property (@(posedge clk) dead_cnt <= DEAD_LOAD);

endmodule
